// File: rtl/axis_rr_arb_n.sv
// N-port AXI-Stream packet arbiter: round-robin or fixed priority, packet-granular
// grants, single registered output stage.
module axis_rr_arb_n #(
  parameter int unsigned N_PORTS  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ARB_MODE = 0,
  localparam int unsigned ID_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                        Aclk,
  input  logic                        Areset_n,
  input  logic [N_PORTS-1:0]          s_axis_tvalid,
  output logic [N_PORTS-1:0]          s_axis_tready,
  input  logic [N_PORTS-1:0]          s_axis_tlast,
  input  logic [N_PORTS*DATA_W-1:0]   s_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic [ID_W-1:0]             m_axis_tid,
  output logic                        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_grant_id;
  logic [ID_W-1:0]    r_last_id;
  logic               r_m_tvalid;
  logic               r_m_tlast;
  logic [DATA_W-1:0]  r_m_tdata;
  logic [ID_W-1:0]    r_m_tid;

  logic [ID_W-1:0]    w_cand;
  logic [ID_W-1:0]    w_sel_id;
  logic               w_sel_found;
  logic [DATA_W-1:0]  w_in_data;
  logic               w_in_valid;
  logic               w_in_last;
  logic               w_out_free;
  logic               w_accept;

  // Candidate order: RR starts one past the last granted port and wraps.
  always_comb begin
    w_cand      = '0;
    w_sel_id    = '0;
    w_sel_found = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (ARB_MODE == 1)
        w_cand = ID_W'(i);
      else
        w_cand = ID_W'((32'(r_last_id) + i + 32'd1) % N_PORTS);
      if (!w_sel_found && s_axis_tvalid[w_cand]) begin
        w_sel_id    = w_cand;
        w_sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_in_data = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (r_grant_id == ID_W'(k))
        w_in_data = s_axis_tdata[k*DATA_W +: DATA_W];
    end
  end

  assign w_in_valid = s_axis_tvalid[r_grant_id];
  assign w_in_last  = s_axis_tlast[r_grant_id];
  assign w_out_free = !r_m_tvalid || m_axis_tready;
  assign w_accept   = (r_state == GRANT) && w_in_valid && w_out_free;

  always_comb begin
    s_axis_tready = '0;
    if (r_state == GRANT)
      s_axis_tready[r_grant_id] = w_out_free;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_sel_found) w_state_nxt = GRANT;
      GRANT:   if (w_accept && w_in_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Aclk or negedge Areset_n) begin
    if (!Areset_n) begin
      r_state    <= IDLE;
      r_grant_id <= '0;
      r_last_id  <= ID_W'(N_PORTS - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_sel_found)
        r_grant_id <= w_sel_id;
      if (w_accept && w_in_last)
        r_last_id <= r_grant_id;
    end
  end

  // Load on accept covers the drain-and-refill case without a bubble.
  always_ff @(posedge Aclk or negedge Areset_n) begin
    if (!Areset_n) begin
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tid    <= '0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_in_last;
      r_m_tdata  <= w_in_data;
      r_m_tid    <= r_grant_id;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tid    = r_m_tid;
  assign busy          = (r_state == GRANT);

endmodule
